// File: rtl/cpu_pkg.sv
// Shared control-flow definitions: opcode classes, branch funct3 codes and
// the resolve-unit state encoding.
package cpu_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {IDLE, RESOLVE, JUMP} state_t;

  function automatic logic is_cf(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch-condition evaluator; reserved funct3 codes never take.
module branch_cmp
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        cond
);

  always_comb begin
    // NOTE: default first so every path assigns cond and no latch is inferred.
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = (rs1 == rs2);
      F3_BNE:  cond = (rs1 != rs2);
      F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: cond = (rs1 <  rs2);
      F3_BGEU: cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Control-flow front of the PC: latches a CF instruction in IDLE, reports the
// branch outcome in RESOLVE (PC stall) and holds targets through JUMP.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      INSTR,
  input  logic [31:0]      RS1_DATA,
  input  logic [31:0]      RS2_DATA,
  output logic [6:0]       OP,
  output logic             b_taken,
  output logic [31:0]      up_amt,
  output logic [11:0]      immm,
  output logic [31:0]      RS1_HOLD,
  output logic [CNT_W-1:0] BR_CNT,
  output logic [CNT_W-1:0] TAKEN_CNT
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state;
  logic [6:0]  op_q;
  logic        taken_q;
  logic        cond;
  logic [31:0] imm_next;

  branch_cmp u_cmp (
    .funct3 (INSTR[14:12]),
    .rs1    (RS1_DATA),
    .rs2    (RS2_DATA),
    .cond   (cond)
  );

  always_comb begin
    imm_next = '0;
    case (INSTR[6:0])
      OP_BRANCH: imm_next = {{20{INSTR[31]}}, INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0};
      OP_JAL:    imm_next = {{12{INSTR[31]}}, INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0};
      default:   imm_next = '0;
    endcase
  end

  // In IDLE the PC sees the fetched opcode directly; afterwards the latched one.
  assign OP      = (state == IDLE) ? INSTR[6:0] : op_q;
  assign b_taken = (state == RESOLVE) && taken_q;

  always_ff @(posedge CLK) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; there are no memories here, so everything is reset.
    if (RESET) begin
      state     <= IDLE;
      op_q      <= '0;
      taken_q   <= 1'b0;
      up_amt    <= '0;
      immm      <= '0;
      RS1_HOLD  <= '0;
      BR_CNT    <= '0;
      TAKEN_CNT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_cf(INSTR[6:0])) begin
            op_q     <= INSTR[6:0];
            taken_q  <= (INSTR[6:0] == OP_BRANCH) && cond;
            up_amt   <= imm_next;
            immm     <= INSTR[31:20];
            RS1_HOLD <= RS1_DATA;
            state    <= RESOLVE;
          end
        end
        RESOLVE: begin
          state <= ((op_q != OP_BRANCH) || taken_q) ? JUMP : IDLE;
          if (op_q == OP_BRANCH) begin
            if (!(&BR_CNT))
              BR_CNT <= BR_CNT + CNT_ONE;
            if (taken_q && !(&TAKEN_CNT))
              TAKEN_CNT <= TAKEN_CNT + CNT_ONE;
          end
        end
        JUMP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus random instructions checked
// against a transaction-level model; a CNT_W=2 copy exercises saturation.
module tb_branch_resolve;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTR = 32'h0000_0013;
  logic [31:0] RS1_DATA = '0;
  logic [31:0] RS2_DATA = '0;

  logic [6:0]  OP, OP_s;
  logic        b_taken, b_taken_s;
  logic [31:0] up_amt, up_amt_s, RS1_HOLD, RS1_HOLD_s;
  logic [11:0] immm, immm_s;
  logic [15:0] BR_CNT, TAKEN_CNT;
  logic [1:0]  BR_CNT_s, TAKEN_CNT_s;

  int checks = 0;
  int errors = 0;

  // Model state: values the PC should see held, and unbounded event counts.
  logic [31:0] exp_up, exp_rs1;
  logic [11:0] exp_imm;
  int br_n, tk_n;

  always #5 CLK = ~CLK;

  branch_resolve #(.CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .OP(OP), .b_taken(b_taken), .up_amt(up_amt), .immm(immm), .RS1_HOLD(RS1_HOLD),
    .BR_CNT(BR_CNT), .TAKEN_CNT(TAKEN_CNT)
  );

  branch_resolve #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .OP(OP_s), .b_taken(b_taken_s), .up_amt(up_amt_s), .immm(immm_s), .RS1_HOLD(RS1_HOLD_s),
    .BR_CNT(BR_CNT_s), .TAKEN_CNT(TAKEN_CNT_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  function automatic bit model_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_held(input string where);
    check({where, "_up_amt"}, up_amt, exp_up);
    check({where, "_immm"}, 32'(immm), 32'(exp_imm));
    check({where, "_rs1_hold"}, RS1_HOLD, exp_rs1);
    check({where, "_br_cnt"}, 32'(BR_CNT), 32'(sat(br_n, 65535)));
    check({where, "_taken_cnt"}, 32'(TAKEN_CNT), 32'(sat(tk_n, 65535)));
    check({where, "_br_cnt_sat"}, 32'(BR_CNT_s), 32'(sat(br_n, 3)));
    check({where, "_taken_cnt_sat"}, 32'(TAKEN_CNT_s), 32'(sat(tk_n, 3)));
  endtask

  // Inputs driven while the unit is busy carry CF opcodes; they must be ignored.
  task automatic drive_garbage();
    logic [31:0] g;
    g = $urandom;
    g[6:0] = ($urandom_range(0, 1) == 0) ? 7'b1100011 : 7'b1101111;
    INSTR = g;
    RS1_DATA = 32'h0000_DEAD;
    RS2_DATA = $urandom;
  endtask

  task automatic zero_model();
    exp_up = '0; exp_imm = '0; exp_rs1 = '0; br_n = 0; tk_n = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    INSTR = 32'h0000_0013;
    @(negedge CLK);
    RESET = 1'b0;
    zero_model();
  endtask

  task automatic idle_check(input string where);
    @(negedge CLK);
    INSTR = 32'h0000_0013;
    #1;
    check({where, "_op"}, 32'(OP), 32'h13);
    check({where, "_b_taken"}, 32'(b_taken), 32'h0);
    check_held(where);
  endtask

  // Presents one instruction in IDLE and follows it through RESOLVE/JUMP.
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    logic [6:0] op;
    bit cf, is_br, taken, jump;
    op = instr[6:0];
    @(negedge CLK);
    INSTR = instr; RS1_DATA = rs1; RS2_DATA = rs2;
    #1;
    check("idle_op", 32'(OP), 32'(op));
    check("idle_b_taken", 32'(b_taken), 32'h0);
    check("idle_up_amt", up_amt, exp_up);
    cf = (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
    if (!cf) return;
    is_br = (op == 7'b1100011);
    taken = is_br && model_cond(instr[14:12], rs1, rs2);
    jump  = taken || !is_br;
    if (is_br)
      exp_up = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (op == 7'b1101111)
      exp_up = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    else
      exp_up = 32'h0;
    exp_imm = instr[31:20];
    exp_rs1 = rs1;
    @(negedge CLK);
    drive_garbage();
    #1;
    check("resolve_op", 32'(OP), 32'(op));
    check("resolve_b_taken", 32'(b_taken), 32'(taken));
    check_held("resolve");
    if (is_br) begin
      br_n++;
      if (taken) tk_n++;
    end
    if (jump) begin
      @(negedge CLK);
      drive_garbage();
      #1;
      check("jump_op", 32'(OP), 32'(op));
      check("jump_b_taken", 32'(b_taken), 32'h0);
      check_held("jump");
    end
  endtask

  initial begin
    logic [31:0] instr, a, b;
    zero_model();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // Reset state with a non-CF instruction passing through.
    @(negedge CLK);
    INSTR = 32'h0040_0033;
    #1;
    check("rst_op", 32'(OP), 32'h33);
    check("rst_b_taken", 32'(b_taken), 32'h0);
    check_held("rst");

    // BEQ x5,x5,-8: taken, full RESOLVE/JUMP sequence.
    run_instr(32'hFE52_8CE3, 32'h5, 32'h5);
    idle_check("beq_after");
    check("beq_up_amt_const", up_amt, 32'hFFFF_FFF8);
    check("beq_br_cnt_const", 32'(BR_CNT), 32'd1);
    check("beq_taken_cnt_const", 32'(TAKEN_CNT), 32'd1);

    // BLT vs BLTU with -1 and 1.
    run_instr(32'h0000_4063, 32'hFFFF_FFFF, 32'h1);
    run_instr(32'h0000_6063, 32'hFFFF_FFFF, 32'h1);
    idle_check("bltu_after");
    check("bltu_taken_cnt_const", 32'(TAKEN_CNT), 32'd2);

    // JAL +2048.
    run_instr(32'h0010_006F, 32'h0, 32'h0);
    check("jal_up_amt_const", up_amt, 32'h0000_0800);

    // JALR x0, -4(x1) with RS1 disturbed during RESOLVE.
    run_instr(32'hFFC0_8067, 32'h0000_1000, 32'h0);
    check("jalr_immm_const", 32'(immm), 32'hFFC);
    check("jalr_rs1_hold_const", RS1_HOLD, 32'h0000_1000);

    // Reset arrives while a taken BEQ is in RESOLVE.
    do_reset();
    @(negedge CLK);
    INSTR = 32'hFE52_8CE3; RS1_DATA = 32'h5; RS2_DATA = 32'h5;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("midrst_b_taken_before", 32'(b_taken), 32'h1);
    @(negedge CLK);
    RESET = 1'b0;
    INSTR = 32'h0000_0013;
    #1;
    check("midrst_op", 32'(OP), 32'h13);
    check("midrst_b_taken", 32'(b_taken), 32'h0);
    check_held("midrst");

    // Counter saturation on the CNT_W=2 copy, then a reserved-funct3 branch.
    for (int i = 0; i < 5; i++)
      run_instr(32'hFE52_8CE3, 32'h5, 32'h5);
    run_instr(32'h0000_2063, 32'h7, 32'h7);
    idle_check("sat_after");
    check("sat_br_cnt_const", 32'(BR_CNT_s), 32'd3);
    check("sat_taken_cnt_const", 32'(TAKEN_CNT_s), 32'd3);
    check("sat_br_cnt_wide_const", 32'(BR_CNT), 32'd6);

    // Random mix of branches, jumps and ordinary instructions.
    for (int i = 0; i < 300; i++) begin
      instr = $urandom;
      case ($urandom_range(0, 4))
        0, 1:    instr[6:0] = 7'b1100011;
        2:       instr[6:0] = 7'b1101111;
        3:       instr[6:0] = 7'b1100111;
        default: instr[6:0] = 7'b0010011;
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = ~a;
        2:       b = a + 32'($urandom_range(0, 2)) - 32'd1;
        default: b = $urandom;
      endcase
      run_instr(instr, a, b);
    end
    idle_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Drives the control-flow side of the program-counter interface.
- Decodes the fetched instruction and evaluates branch conditions against register operands.
- Presents OP, b_taken, up_amt, immm and a held RS1 value, timed to the PC's three-state INC4/STALL/JUMP sequence.
- Sits between instruction fetch/register file and the PC. It also keeps saturating branch statistics counters.

Parameters:
- CNT_W, 16, width of the branch-executed and branch-taken statistics counters.

Ports:
- CLK  input  1  system clock, rising-edge.
- RESET  input  1  synchronous, active-high reset.
- INSTR  input  32  instruction currently fetched at IP.
- RS1_DATA  input  32  register-file read of INSTR[19:15].
- RS2_DATA  input  32  register-file read of INSTR[24:20].
- OP  output  7  opcode presented to PC.
- b_taken  output  1  conditional branch taken, valid in RESOLVE.
- up_amt  output  32  signed PC offset (B-imm or J-imm).
- immm  output  12  signed I-immediate for JALR.
- RS1_HOLD  output  32  latched RS1 for JALR target.
- BR_CNT  output  CNT_W  conditional branches resolved, saturating.
- TAKEN_CNT  output  CNT_W  conditional branches taken, saturating.

Behaviour:
- Reset is synchronous, active-high. On RESET: state=IDLE and all latches cleared. Outputs then read OP=INSTR[6:0] (IDLE passthrough), b_taken=0, up_amt=0, immm=0, RS1_HOLD=0, BR_CNT=0, TAKEN_CNT=0. RESET takes priority in any state, including mid-RESOLVE/JUMP; counters are not updated on that edge.
- Opcode classes:
  - BRANCH = 7'b1100011
  - JAL = 7'b1101111
  - JALR = 7'b1100111
  - CF = any of the three.
- IDLE:
  - OP = INSTR[6:0], combinational.
  - b_taken=0.
  - up_amt/immm/RS1_HOLD show latched values.
  - If INSTR[6:0] is CF, on the clock edge latch: opcode, funct3=INSTR[14:12], cond result, up_amt, immm=INSTR[31:20], RS1_HOLD=RS1_DATA. Then go to RESOLVE.
  - Otherwise stay in IDLE.
- up_amt selection:
  - BRANCH: B-imm = sext{INSTR[31],INSTR[7],INSTR[30:25],INSTR[11:8],0}.
  - JAL: J-imm = sext{INSTR[31],INSTR[19:12],INSTR[20],INSTR[30:21],0}.
  - JALR: 0.
- cond (BRANCH only, computed on the RS1_DATA/RS2_DATA sampled at the latch edge):
  - funct3 000 BEQ (==)
  - 001 BNE (!=)
  - 100 BLT (signed <)
  - 101 BGE (signed >=)
  - 110 BLTU (unsigned <)
  - 111 BGEU (unsigned >=)
  - 010/011: cond=0.
- RESOLVE (exactly one cycle after latch; this is the PC's STALL cycle):
  - OP = latched opcode.
  - b_taken = cond if latched opcode is BRANCH, else 0.
  - Next state: JUMP if b_taken, JAL or JALR; otherwise IDLE.
  - Leaving RESOLVE with a BRANCH increments BR_CNT, and also TAKEN_CNT if taken. Each counter holds at all-ones.
- JUMP (one cycle, the PC's redirect cycle):
  - OP = latched opcode, so the PC can select the JALR formula.
  - b_taken=0.
  - up_amt/immm/RS1_HOLD held.
  - Next state is always IDLE.
- Latency: CF instruction at IDLE edge n gives b_taken at cycle n+1; redirect completes at edge n+2.
- INSTR/RS*_DATA are ignored outside IDLE. Back-to-back CF instructions are handled because the unit re-enters IDLE before the next fetch.
- Arithmetic: all immediates are sign-extended from bit 31 of INSTR; no overflow handling is required.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - funct3 constants F3_BEQ…F3_BGEU.
  - state enum {IDLE, RESOLVE, JUMP}.
- One natural sub-module, branch_cmp: combinational 32-bit comparator taking funct3, rs1, rs2 and returning cond.
- Immediate generation stays inline.

Test Plan:
- BEQ with rs1=rs2=0x5, imm=-8 (INSTR=0xFE528CE3) → RESOLVE cycle shows OP=1100011, b_taken=1, up_amt=0xFFFFFFF8; next cycle JUMP; then IDLE; BR_CNT=1, TAKEN_CNT=1.
- BLT with rs1=0xFFFFFFFF, rs2=1 → b_taken=1. Same operands with BLTU → b_taken=0 and a return to IDLE after RESOLVE; TAKEN_CNT unchanged.
- JAL offset +2048 → RESOLVE b_taken=0, up_amt=0x00000800; JUMP holds OP=1101111.
- JALR with rs1=0x1000, imm=-4 → immm=0xFFC, RS1_HOLD=0x1000 through JUMP, even if RS1_DATA changes to 0xDEAD in RESOLVE.
- RESET asserted during RESOLVE of a taken BEQ → next cycle IDLE, b_taken=0, up_amt=0, counters unchanged/zero.
- CNT_W=2, five taken branches → BR_CNT and TAKEN_CNT saturate at 3; funct3=010 branch → not taken, BR_CNT still 3.
